// File: rtl/ebus_arb_if.sv
// EBUS arbiter signal bundle: per-master request side plus the shared EBUS control/DS lines.
// The master modport is the arbiter; slave is the requesters and the addressed device.
interface ebus_arb_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0]   req;
   logic [8*N-1:0] reqDS;
   logic [3*N-1:0] reqFunc;
   logic           ebusXfer;
   logic [N-1:0]   grant;
   logic [0:7]     EBUS_DS;
   logic           ebusDSStrobe;
   logic [0:2]     ebusFunc;
   logic           ebusDemand;
   logic           ebusReturn;
   logic [N-1:0]   done;
   logic           timeout;
   logic           busy;

   modport master (
      input  req, reqDS, reqFunc, ebusXfer,
      output grant, EBUS_DS, ebusDSStrobe, ebusFunc, ebusDemand, ebusReturn, done, timeout,
             busy
   );

   modport slave (
      output req, reqDS, reqFunc, ebusXfer,
      input  grant, EBUS_DS, ebusDSStrobe, ebusFunc, ebusDemand, ebusReturn, done, timeout,
             busy
   );
endinterface

// File: rtl/ebus_arb.sv
// EBUS master arbiter: round-robin grant among N masters, then sequences select, demand,
// acknowledge-or-timeout and bus return. Every output is a register.
module ebus_arb #(
   parameter int unsigned N         = 4,
   parameter int unsigned DS_CYCLES = 2,
   parameter int unsigned TIMEOUT   = 64
) (
   input logic        clk,
   input logic        RESET,
   ebus_arb_if.master bus
);
   localparam int unsigned IW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CMAX = (TIMEOUT > DS_CYCLES) ? TIMEOUT : DS_CYCLES;
   localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [2:0] {StIdle, StSelect, StDemand, StReturn, StWaitDrop} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] win_q, win_d, last_q, last_d;
   logic [IW-1:0] pick, cand;
   logic          pick_ok;
   logic [7:0]    pick_ds, ds_q, ds_d, ds_out_q, ds_out_d;
   logic [2:0]    pick_func, func_q, func_d, func_out_q, func_out_d;
   logic [N-1:0]  win_oh;
   logic [N-1:0]  grant_q, grant_d, done_q, done_d;
   logic          strobe_q, strobe_d, demand_q, demand_d, return_q, return_d;
   logic          timeout_q, timeout_d, busy_q, busy_d;
   logic          hold, drive;

   // Scan offsets from far to near so the nearest requester after last overwrites the rest.
   always_comb begin
      pick      = last_q;
      cand      = last_q;
      pick_ok   = |bus.req;
      pick_ds   = '0;
      pick_func = '0;
      for (int k = int'(N); k >= 1; k--) begin
         cand = IW'((int'(last_q) + k) % int'(N));
         if ((bus.req & (N'(1) << cand)) != '0) pick = cand;
      end
      for (int i = 0; i < int'(N); i++) begin
         if (pick == IW'(i)) begin
            pick_ds   = bus.reqDS[8*i +: 8];
            pick_func = bus.reqFunc[3*i +: 3];
         end
      end
   end

   assign win_oh = N'(1) << win_q;

   // Outputs are computed for the state being entered, so they register alongside it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      win_d     = win_q;
      last_d    = last_q;
      ds_d      = ds_q;
      func_d    = func_q;
      hold      = 1'b0;
      drive     = 1'b0;
      strobe_d  = 1'b0;
      demand_d  = 1'b0;
      return_d  = 1'b0;
      timeout_d = 1'b0;
      done_d    = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_ok) begin
               state_d  = StSelect;
               win_d    = pick;
               last_d   = pick;
               ds_d     = pick_ds;
               func_d   = pick_func;
               cnt_d    = '0;
               hold     = 1'b1;
               drive    = 1'b1;
               strobe_d = 1'b1;
            end
         end
         StSelect: begin
            hold  = 1'b1;
            drive = 1'b1;
            if (cnt_q == CW'(DS_CYCLES - 1)) begin
               state_d  = StDemand;
               cnt_d    = '0;
               demand_d = 1'b1;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               strobe_d = 1'b1;
            end
         end
         StDemand: begin
            hold  = 1'b1;
            drive = 1'b1;
            // Acknowledge takes priority over a timeout landing in the same cycle.
            if (bus.ebusXfer) begin
               state_d  = StReturn;
               return_d = 1'b1;
               done_d   = win_oh;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d   = StReturn;
               return_d  = 1'b1;
               timeout_d = 1'b1;
            end else begin
               cnt_d    = cnt_q + 1'b1;
               demand_d = 1'b1;
            end
         end
         StReturn: begin
            state_d = StWaitDrop;
            hold    = 1'b1;
         end
         StWaitDrop: begin
            if ((bus.req & win_oh) != '0) hold = 1'b1;
            else state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      grant_d    = hold ? (N'(1) << win_d) : '0;
      busy_d     = hold;
      ds_out_d   = drive ? ds_d : '0;
      func_out_d = drive ? func_d : '0;
   end

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         win_q      <= '0;
         last_q     <= IW'(N - 1);
         ds_q       <= '0;
         func_q     <= '0;
         grant_q    <= '0;
         ds_out_q   <= '0;
         func_out_q <= '0;
         strobe_q   <= 1'b0;
         demand_q   <= 1'b0;
         return_q   <= 1'b0;
         done_q     <= '0;
         timeout_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         win_q      <= win_d;
         last_q     <= last_d;
         ds_q       <= ds_d;
         func_q     <= func_d;
         grant_q    <= grant_d;
         ds_out_q   <= ds_out_d;
         func_out_q <= func_out_d;
         strobe_q   <= strobe_d;
         demand_q   <= demand_d;
         return_q   <= return_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.grant        = grant_q;
   assign bus.EBUS_DS      = ds_out_q;
   assign bus.ebusDSStrobe = strobe_q;
   assign bus.ebusFunc     = func_out_q;
   assign bus.ebusDemand   = demand_q;
   assign bus.ebusReturn   = return_q;
   assign bus.done         = done_q;
   assign bus.timeout      = timeout_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_ebus_arb.sv
// Bench for ebus_arb: table of directed transactions, reset corner cases, then random
// transactions predicted by a transaction-level round-robin / timeline model.
module tb_ebus_arb;
   localparam int unsigned N  = 4;
   localparam int unsigned DS = 2;
   localparam int unsigned TO = 64;

   logic clk = 1'b0;
   logic RESET;
   int   n_vec = 0;
   int   n_bad = 0;
   int   rr_last;

   ebus_arb_if #(.N(N)) bus();

   ebus_arb #(.N(N), .DS_CYCLES(DS), .TIMEOUT(TO)) dut (
      .clk  (clk),
      .RESET(RESET),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] mask;
      int           xfer_at;   // DEMAND cycle (0-based) carrying ebusXfer; >= TO means never
      int           drop_rel;  // winner drops req this many cycles after the first WAITDROP
      bit           pin;       // force master 1 DS=A5, func=101
      bit           scr;       // scribble on requests while the transfer runs
      int           win;
      bit           ok;
   } vec_t;

   vec_t tbl[11];

   function automatic logic [63:0] outs();
      return 64'({bus.grant, bus.EBUS_DS, bus.ebusDSStrobe, bus.ebusFunc, bus.ebusDemand,
                  bus.ebusReturn, bus.done, bus.timeout, bus.busy});
   endfunction

   function automatic logic [63:0] pack(input logic [N-1:0] g, input logic [7:0] d,
                                        input logic s, input logic [2:0] f, input logic dm,
                                        input logic r, input logic [N-1:0] dn, input logic t,
                                        input logic b);
      return 64'({g, d, s, f, dm, r, dn, t, b});
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Round-robin reference: first requester found walking upward from last+1, with wrap.
   function automatic int rr_pick(input logic [N-1:0] m, input int last);
      logic [2*N-1:0] dbl;
      int             base;
      dbl  = {m, m};
      base = (last + 1) % N;
      for (int d = 0; d < N; d++) if (dbl[base + d]) return (base + d) % N;
      return -1;
   endfunction

   // Entered just after a negedge with the DUT in IDLE; leaves it at a negedge in IDLE.
   task automatic run_txn(input logic [N-1:0] mask, input int xfer_at, input int drop_rel,
                          input bit pin, input bit scr, input int win, input bit ok);
      logic [8*N-1:0] dsv;
      logic [3*N-1:0] fnv;
      logic [N-1:0]   oh;
      logic [7:0]     eds;
      logic [2:0]     efn;
      int             k_ret, drop_k, wd_last;
      for (int i = 0; i < N; i++) begin
         dsv[8*i +: 8] = 8'($urandom);
         fnv[3*i +: 3] = 3'($urandom);
      end
      if (pin) begin
         dsv[15:8] = 8'hA5;
         fnv[5:3]  = 3'b101;
      end
      oh      = N'(1) << win;
      eds     = dsv[8*win +: 8];
      efn     = fnv[3*win +: 3];
      k_ret   = DS + 1 + (ok ? xfer_at + 1 : TO);
      drop_k  = k_ret + 1 + drop_rel;
      wd_last = (drop_k > k_ret + 1) ? drop_k : k_ret + 1;
      bus.req      = mask;
      bus.reqDS    = dsv;
      bus.reqFunc  = fnv;
      bus.ebusXfer = 1'b0;
      for (int k = 1; k <= wd_last + 1; k++) begin
         @(negedge clk);
         check($sformatf("txn win%0d cycle%0d", win, k), outs(),
               pack((k <= wd_last) ? oh : '0, (k <= k_ret) ? eds : 8'h00, k <= DS,
                    (k <= k_ret) ? efn : 3'b000, k > DS && k < k_ret, k == k_ret,
                    (k == k_ret && ok) ? oh : '0, k == k_ret && !ok, k <= wd_last));
         bus.ebusXfer = ok && (k == DS + 1 + xfer_at);
         if (scr && k <= wd_last) begin
            for (int i = 0; i < N; i++) begin
               bus.reqDS[8*i +: 8]   = 8'($urandom);
               bus.reqFunc[3*i +: 3] = 3'($urandom);
            end
            bus.req = (N'($urandom) & ~oh) | (bus.req & oh);
         end
         if (k == drop_k) bus.req = bus.req & ~oh;
      end
      bus.req      = '0;
      bus.ebusXfer = 1'b0;
      rr_last      = win;
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 0,      1,  1'b0, 1'b0, 0, 1'b1};  // single request
      tbl[1]  = '{4'b1111, 2,      0,  1'b0, 1'b0, 1, 1'b1};  // round-robin sweep
      tbl[2]  = '{4'b1101, 1,      0,  1'b0, 1'b0, 2, 1'b1};
      tbl[3]  = '{4'b1011, 0,      2,  1'b0, 1'b0, 3, 1'b1};
      tbl[4]  = '{4'b0111, 3,      0,  1'b0, 1'b0, 0, 1'b1};
      tbl[5]  = '{4'b1111, 0,      0,  1'b0, 1'b0, 1, 1'b1};
      tbl[6]  = '{4'b0100, TO,     0,  1'b0, 1'b0, 2, 1'b0};  // timeout
      tbl[7]  = '{4'b1000, TO - 1, 0,  1'b0, 1'b0, 3, 1'b1};  // xfer in last DEMAND cycle
      tbl[8]  = '{4'b0010, 4,      1,  1'b1, 1'b1, 1, 1'b1};  // DS/func latch
      tbl[9]  = '{4'b1001, 0,      -3, 1'b0, 1'b0, 3, 1'b1};  // req dropped mid-transfer
      tbl[10] = '{4'b1001, 1,      0,  1'b0, 1'b1, 0, 1'b1};

      RESET        = 1'b1;
      bus.req      = '0;
      bus.reqDS    = '0;
      bus.reqFunc  = '0;
      bus.ebusXfer = 1'b0;
      rr_last      = N - 1;
      #2;
      check("reset outputs", outs(), '0);
      @(negedge clk);
      @(negedge clk);
      RESET = 1'b0;
      @(negedge clk);
      check("idle after reset", outs(), '0);

      for (int v = 0; v < 11; v++) begin
         run_txn(tbl[v].mask, tbl[v].xfer_at, tbl[v].drop_rel, tbl[v].pin, tbl[v].scr,
                 tbl[v].win, tbl[v].ok);
      end

      // Reset in the middle of DEMAND while master 1 holds the bus.
      bus.req = 4'b0010;
      repeat (DS + 3) @(negedge clk);
      check("demand before reset", 64'(bus.ebusDemand), 64'd1);
      @(posedge clk);
      #3 RESET = 1'b1;
      #1 check("async reset mid-demand", outs(), '0);
      @(negedge clk);
      check("reset held", outs(), '0);
      bus.req = '0;
      RESET   = 1'b0;
      rr_last = N - 1;
      run_txn(4'b0110, 1, 0, 1'b0, 1'b0, 1, 1'b1);

      for (int r = 0; r < 60; r++) begin
         logic [N-1:0] m;
         int           xa, w;
         m  = N'($urandom_range(1, (1 << N) - 1));
         xa = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 7))
                                          : int'($urandom_range(0, TO + 2));
         w  = rr_pick(m, rr_last);
         run_txn(m, xa, int'($urandom_range(0, 6)) - 3, 1'b0, bit'($urandom_range(0, 1)), w,
                 xa < TO);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ebus_arb.md
# ebus_arb

EBUS master arbiter and transfer sequencer. Shares the single EBUS among N on-board masters (APR, PI, EBOX I/O instruction path, CTY/console) with round-robin priority. It sequences each transfer: device-select setup, demand, wait for transfer acknowledge or timeout, then return. It sits between the requesting masters and the EBUS control/DS lines and is the only driver of ebusDemand, ebusReturn, EBUS_DS and ebusDSStrobe.

## Interface
- N, 4: number of requesting masters (2..8).
- DS_CYCLES, 2: cycles ebusDSStrobe is held high during select (≥1).
- TIMEOUT, 64: maximum cycles in DEMAND before forced abort (≥2).

- clk  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req  in  N  per-master request level; held until done/timeout seen.
- reqDS  in  8*N  device select; master i owns bits 8i..8i+7.
- reqFunc  in  3*N  EBUS function code; master i owns bits 3i..3i+2.
- ebusXfer  in  1  device transfer acknowledge.
- grant  out  N  one-hot, high from SELECT through WAITDROP.
- EBUS_DS  out  [0:7]  latched DS of the granted master, else 0.
- ebusDSStrobe  out  1  DS strobe.
- ebusFunc  out  [0:2]  latched function of the granted master, else 0.
- ebusDemand  out  1  transfer demand.
- ebusReturn  out  1  one-cycle bus-release pulse.
- done  out  N  one-cycle pulse to the granted master on successful transfer.
- timeout  out  1  one-cycle pulse on aborted transfer.
- busy  out  1  high in every state but IDLE.

## Operation
- States: IDLE, SELECT, DEMAND, RETURN, WAITDROP.
- IDLE: if any req bit is set, choose the winner round-robin, searching from (last+1) mod N upward with wrap. Latch the winner index, its DS and its function. Next state is SELECT. last ← winner.
- SELECT: grant[winner]=1. EBUS_DS and ebusFunc are driven. ebusDSStrobe=1 for exactly DS_CYCLES cycles, then next state is DEMAND. The cycle counter is cleared on entry.
- DEMAND: ebusDemand=1. The counter increments each cycle.
  - ebusXfer=1 → RETURN with ok.
  - Otherwise counter==TIMEOUT-1 → RETURN with abort.
  - If both occur in the same cycle, xfer wins (ok).
- RETURN (1 cycle): ebusReturn=1. Either done[winner]=1 (ok) or timeout=1 (abort). ebusDemand=0 and ebusDSStrobe=0. DS and function remain driven. Next state is WAITDROP.
- WAITDROP: grant is held. EBUS_DS and ebusFunc are 0. The state stays until req[winner]=0, then goes to IDLE. This prevents a stale level from being re-granted.
- Changes to req, reqDS or reqFunc after the latch are ignored until the next arbitration. A master dropping req mid-transfer does not abort the transfer.
- Reset (asynchronous, any state):
  - State → IDLE, last ← N-1, so master 0 wins first.
  - Counter and latches are cleared.
  - All outputs are 0.

## Timing
- All outputs are registered.
- req rises in cycle t (IDLE) → grant and the first strobe cycle appear at t+1.
- ebusDemand first rises at t+1+DS_CYCLES.
- ebusXfer sampled high in cycle d → ebusReturn and done at d+1. The next grant is no earlier than d+3 (via WAITDROP, with req dropped at d+2).
- Timeout: ebusDemand is high exactly TIMEOUT cycles, and the timeout pulse occurs in the following cycle.
- Minimum idle-to-idle transaction with immediate xfer and prompt req drop: DS_CYCLES+4 cycles.

## Test plan
- Single request, N=4: req=0001 and ebusXfer high in the 1st DEMAND cycle. Required: grant=0001 for 1+DS_CYCLES+3 cycles, ebusDSStrobe high 2 cycles, one ebusReturn pulse, done=0001 once.
- Round-robin: req=1111 held, and each master drops req after its own done. Required: grant order 0,1,2,3, then 0 again when it re-requests; no master is granted twice while others wait.
- Timeout: request with ebusXfer never asserted. Required: ebusDemand high exactly 64 cycles, timeout pulse 1 cycle, done stays 0, ebusReturn pulses.
- Boundary: ebusXfer asserted in the 64th DEMAND cycle. Required: done pulses and timeout stays 0.
- Reset mid-DEMAND: assert RESET asynchronously between edges. Required: all outputs 0 immediately. After release with req=0110, master 1 wins first.
- DS/func latch: reqDS[8:15]=8'hA5 and func=3'b101 at grant, then reqDS changed during DEMAND. Required: EBUS_DS stays A5 and ebusFunc stays 101 through RETURN, and both are 0 in WAITDROP.
